axi_stream_arbiter: RTL and testbench
=====================================

# axi_stream_arbiter

Shares the single AXI-Stream master output of the snooping bridge between the per-channel snooper submodules (AW, W, B, AR, R). Each submodule presents `valid`/`in_progress`/`last`/`data` and receives a `ready`. The arbiter grants exactly one submodule at a time, round-robin, and muxes its payload to the stream port. It holds the grant until that submodule's last beat is accepted.

## Interface
- `NUM_SRC`, 5: number of snooper submodules.
- `DATA_WIDTH`, 128: stream data width; equals the submodules' `data` width.
- `CNT_WIDTH`, 32: width of each packet counter (feature-gated).
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `src_valid` in NUM_SRC: per-source valid.
- `src_in_progress` in NUM_SRC: source is mid-burst.
- `src_last` in NUM_SRC: source's current beat is last.
- `src_data` in NUM_SRC*DATA_WIDTH: source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `src_ready` out NUM_SRC: per-source ready.
- `m_axis_tdata` out DATA_WIDTH: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tlast` out 1: stream last.
- `m_axis_tready` in 1: stream ready.
- `grant` out NUM_SRC: one-hot current grant; all-zero when idle.
- `pkt_count` out NUM_SRC*CNT_WIDTH: per-source completed-packet counters (only with macro).

## Operation
- FSM states:
  - ARB: `grant`=0, all `src_ready`=0, `m_axis_tvalid`=0. If any `src_valid` is high, register a one-hot grant to the first requester searching from `rr_ptr` upward, with wrap-around, then go to XFER.
  - XFER: granted source g is wired through:
    - `src_ready[g]` = `m_axis_tready`; all other `src_ready` are 0.
    - `m_axis_tvalid` = `src_valid[g]`.
    - `m_axis_tdata` = `src_data[g]`.
    - `m_axis_tlast` = `src_last[g]`.
- A beat is accepted when `m_axis_tvalid && m_axis_tready`.
- Leave XFER for ARB on:
  - a beat with `m_axis_tlast` = 1, or
  - `src_valid[g]` = 0 and `src_in_progress[g]` = 0 (source withdrew).
- On leaving XFER, set `rr_ptr` ← g+1 mod NUM_SRC.
- While `src_in_progress[g]` = 1, the grant is never released, even if valid drops for some cycles.
- `src_last` from snoopers depends combinationally on `ready`. Therefore `src_ready` must be combinational from `m_axis_tready`, with no register in that path.
- Simultaneous requests: round-robin order from `rr_ptr`. A source that just finished has lowest priority in the next ARB.
- `m_axis_tdata` is 0 when not in XFER.
- Reset (async, any cycle including mid-burst):
  - state = ARB, `grant` = 0, `rr_ptr` = 0, counters = 0.
  - All outputs drop to 0 immediately.
  - The interrupted packet is not resumed.

## Timing
- Arbitration latency: 1 cycle from `src_valid` high in ARB to the grant visible in XFER.
- Payload path is combinational in XFER: zero-latency pass-through of data/valid/last; ready is combinational back to the source.
- Return to ARB takes 1 cycle. Minimum throughput is one single-beat packet per 2 cycles. A burst of N beats takes N+1 cycles at full `m_axis_tready`.
- Backpressure: `m_axis_tready` = 0 holds everything; the grant is unchanged.

## Configuration
- `AXI_STREAM_ARBITER_PKT_CNT_EN` defined: `pkt_count[i]` increments by 1 on every beat accepted with `m_axis_tlast` while `grant[i]` is set. Counters saturate at all-ones and reset to 0.
- Macro undefined: the `pkt_count` port and counters are absent; everything else is unchanged.

## Structure
- Shared package (`eth_helper_pkg`):
  - FSM state enum {ARB, XFER}.
  - Stream-type constants (3-bit codes per channel, e.g. B = 3'b100) and `STREAM_TYPE_WIDTH` = 3.
- One sub-module, `rr_select`: a combinational round-robin one-hot picker with inputs request vector and pointer, output one-hot. It is reusable elsewhere.

## Test plan
- Single B request: src 2 valid+last, tready = 1.
  - Expected: grant = 5'b00100 next cycle; one beat with tlast; src_ready[2] high that cycle; back to ARB; rr_ptr = 3.
- All five sources valid continuously, single-beat each, tready = 1.
  - Expected: grant order 0,1,2,3,4,0…; one packet per 2 cycles; no source starved.
- 4-beat W burst on src 1 (in_progress high beats 1-3), src 0 also valid.
  - Expected: grant held on src 1 across all 4 beats; src 0 granted only after src 1's tlast beat.
- Backpressure: tready = 0 for 3 cycles mid-burst.
  - Expected: tdata/tvalid stable, src_ready = 0, grant unchanged; resume on tready = 1.
- Withdrawal: granted source drops valid with in_progress = 0 before any beat.
  - Expected: return to ARB next cycle; no beat emitted.
- Async reset asserted mid-burst.
  - Expected: grant, tvalid, src_ready all 0 immediately.
  - With macro: pkt_count = 0.
  - After release, arbitration restarts from src 0.

Source files
------------

// File: rtl/eth_helper_pkg.sv
// eth_helper_pkg: shared FSM states and stream-type codes for the snooping bridge
package eth_helper_pkg;
  typedef enum logic {ARB, XFER} state_e;
  localparam int STREAM_TYPE_WIDTH = 3;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_AW = 3'b000;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_W  = 3'b001;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_AR = 3'b010;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_R  = 3'b011;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_B  = 3'b100;
endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin one-hot picker, first request at or above ptr with wrap
module rr_select #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);
  int   idx;
  logic found;
  // scan N positions starting at ptr, keep the first requester
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_stream_arbiter.sv
// axi_stream_arbiter: round-robin share of one AXI-Stream master among snooper sources;
// define AXI_STREAM_ARBITER_PKT_CNT_EN to add saturating per-source packet counters (pkt_count)
module axi_stream_arbiter
  import eth_helper_pkg::*;
#(
  parameter int NUM_SRC    = 5,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_in_progress,
  input  logic [NUM_SRC-1:0]            src_last,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [NUM_SRC-1:0]            grant
`ifdef AXI_STREAM_ARBITER_PKT_CNT_EN
  ,
  output logic [NUM_SRC*CNT_WIDTH-1:0]  pkt_count
`endif
);
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d, pick;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, g_idx;
  logic               in_xfer, g_busy, accept;
  rr_select #(.N(NUM_SRC), .PTR_W(PTR_W)) u_rr (
    .req(src_valid),
    .ptr(rr_ptr_q),
    .gnt(pick)
  );
  assign in_xfer       = (state_q == XFER);
  assign m_axis_tvalid = in_xfer & |(src_valid & grant_q);
  assign m_axis_tlast  = in_xfer & |(src_last & grant_q);
  assign g_busy        = in_xfer & |(src_in_progress & grant_q);
  assign src_ready     = in_xfer ? (grant_q & {NUM_SRC{m_axis_tready}}) : '0;
  assign accept        = m_axis_tvalid & m_axis_tready;
  assign grant         = grant_q;
  // payload mux and binary index of the granted source
  always_comb begin
    g_idx        = '0;
    m_axis_tdata = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (in_xfer && grant_q[i]) begin
        g_idx        = PTR_W'(i);
        m_axis_tdata = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  // grant on any request in ARB; release on last beat or withdrawal, finished source goes to the back
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (!in_xfer) begin
      if (|src_valid) begin
        state_d = XFER;
        grant_d = pick;
      end
    end else if ((accept && m_axis_tlast) || (!m_axis_tvalid && !g_busy)) begin
      state_d  = ARB;
      grant_d  = '0;
      rr_ptr_d = (g_idx == PTR_W'(NUM_SRC - 1)) ? '0 : g_idx + PTR_W'(1);
    end
  end
  // arbiter state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ARB;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
`ifdef AXI_STREAM_ARBITER_PKT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_SRC];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_SRC];
  // count accepted last beats of the granted source, saturating at all-ones
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++)
      cnt_d[i] = (accept && m_axis_tlast && grant_q[i] && cnt_q[i] != '1) ? cnt_q[i] + CNT_WIDTH'(1) : cnt_q[i];
  end
  // packet counter registers
  always_ff @(posedge clk or negedge resetn) begin
    for (int i = 0; i < NUM_SRC; i++)
      cnt_q[i] <= !resetn ? '0 : cnt_d[i];
  end
  for (genvar c = 0; c < NUM_SRC; c++) begin : g_cnt
    assign pkt_count[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q[c];
  end
`endif
endmodule

// File: tb/tb_axi_stream_arbiter.sv
// tb_axi_stream_arbiter: directed vectors for the round-robin stream arbiter
module tb_axi_stream_arbiter;
  localparam int N  = 5;
  localparam int DW = 128;
  localparam int CW = 32;
  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    valid, inprog, last, src_ready, grant;
  logic [N*DW-1:0] data;
  logic [DW-1:0]   tdata;
  logic            tvalid, tlast, tready;
`ifdef AXI_STREAM_ARBITER_PKT_CNT_EN
  logic [N*CW-1:0] pkt_count;
`endif
  int vectors = 0;
  int miscompares = 0;
  axi_stream_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .resetn(resetn),
    .src_valid(valid),
    .src_in_progress(inprog),
    .src_last(last),
    .src_data(data),
    .src_ready(src_ready),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tlast(tlast),
    .m_axis_tready(tready),
    .grant(grant)
`ifdef AXI_STREAM_ARBITER_PKT_CNT_EN
    ,
    .pkt_count(pkt_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [DW-1:0] sdat(input int i);
    logic [31:0] w;
    w = 32'hD000_0000 | i;
    return {4{w}};
  endfunction
  initial begin
    resetn = 1'b0;
    tready = 1'b1;
    valid  = '0;
    inprog = '0;
    last   = '0;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = sdat(i);
    #2;
    chk("rst_grant", DW'(grant), 0);
    chk("rst_tvalid", DW'(tvalid), 0);
    chk("rst_ready", DW'(src_ready), 0);
    chk("rst_tdata", tdata, 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("idle_grant", DW'(grant), 0);
    // single-beat request on src 2
    valid = 5'b00100;
    last  = 5'b00100;
    #1;
    chk("arb_tvalid", DW'(tvalid), 0);
    chk("arb_tdata", tdata, 0);
    tick();
    chk("b_grant", DW'(grant), 5'b00100);
    chk("b_tvalid", DW'(tvalid), 1);
    chk("b_tlast", DW'(tlast), 1);
    chk("b_ready", DW'(src_ready), 5'b00100);
    chk("b_tdata", tdata, sdat(2));
    tick();
    chk("b_done", DW'(grant), 0);
`ifdef AXI_STREAM_ARBITER_PKT_CNT_EN
    chk("b_cnt", DW'(pkt_count[2*CW +: CW]), 1);
`endif
    // all sources requesting: rr_ptr is 3 after src 2 finished
    valid = '1;
    last  = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr_grant%0d", k), DW'(grant), DW'(1) << ((3 + k) % N));
      chk($sformatf("rr_ready%0d", k), DW'(src_ready), DW'(1) << ((3 + k) % N));
      chk($sformatf("rr_tdata%0d", k), tdata, sdat((3 + k) % N));
      tick();
      chk($sformatf("rr_gap%0d", k), DW'(grant), 0);
    end
    valid = '0;
    last  = '0;
    // 4-beat burst on src 1 (rr_ptr now 4, src 1 alone requests first)
    valid = 5'b00010;
    inprog = 5'b00010;
    data[1*DW +: DW] = DW'(128'hB1);
    tick();
    chk("w_grant1", DW'(grant), 5'b00010);
    chk("w_tdata1", tdata, DW'(128'hB1));
    valid[0] = 1'b1;
    last[0]  = 1'b1;
    tick();
    valid[1] = 1'b0;
    #1;
    chk("w_hold_grant", DW'(grant), 5'b00010);
    chk("w_hold_tvalid", DW'(tvalid), 0);
    tick();
    chk("w_hold_grant2", DW'(grant), 5'b00010);
    valid[1] = 1'b1;
    data[1*DW +: DW] = DW'(128'hB2);
    #1;
    chk("w_tdata2", tdata, DW'(128'hB2));
    tick();
    data[1*DW +: DW] = DW'(128'hB3);
    tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready%0d", k), DW'(src_ready), 0);
      chk($sformatf("bp_tvalid%0d", k), DW'(tvalid), 1);
      chk($sformatf("bp_tdata%0d", k), tdata, DW'(128'hB3));
      chk($sformatf("bp_grant%0d", k), DW'(grant), 5'b00010);
      tick();
    end
    tready = 1'b1;
    #1;
    chk("bp_resume_ready", DW'(src_ready), 5'b00010);
    tick();
    data[1*DW +: DW] = DW'(128'hB4);
    last[1]   = 1'b1;
    inprog[1] = 1'b0;
    #1;
    chk("w_grant4", DW'(grant), 5'b00010);
    chk("w_tlast4", DW'(tlast), 1);
    chk("w_tdata4", tdata, DW'(128'hB4));
    tick();
    chk("w_end", DW'(grant), 0);
    valid[1] = 1'b0;
    last[1]  = 1'b0;
    tick();
    chk("w_src0", DW'(grant), 5'b00001);
    chk("w_src0_tdata", tdata, sdat(0));
    tick();
    valid = '0;
    last  = '0;
    chk("w_src0_done", DW'(grant), 0);
    // withdrawal: rr_ptr 1, src 3 requests then drops before any beat
    valid = 5'b01000;
    tick();
    chk("wd_grant", DW'(grant), 5'b01000);
    valid = '0;
    #1;
    chk("wd_tvalid", DW'(tvalid), 0);
    chk("wd_grant_held", DW'(grant), 5'b01000);
    tick();
    chk("wd_back", DW'(grant), 0);
    // async reset mid-burst on src 4
    valid  = 5'b10000;
    inprog = 5'b10000;
    tick();
    chk("rb_grant", DW'(grant), 5'b10000);
    #2;
    resetn = 1'b0;
    #1;
    chk("rb_grant0", DW'(grant), 0);
    chk("rb_tvalid0", DW'(tvalid), 0);
    chk("rb_ready0", DW'(src_ready), 0);
    chk("rb_tdata0", tdata, 0);
`ifdef AXI_STREAM_ARBITER_PKT_CNT_EN
    chk("rb_cnt0", DW'(pkt_count), 0);
`endif
    resetn = 1'b1;
    valid  = '1;
    last   = '1;
    inprog = '0;
    tick();
    chk("rb_restart", DW'(grant), 5'b00001);
    tick();
    valid = '0;
    last  = '0;
    chk("rb_done", DW'(grant), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
